// File: rtl/shift_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// shift_ctrl_pkg
//   Shared types and helpers for the rotating-LED step controller.
//   - speed_t       : 2-bit speed index (step period = base >> index)
//   - dbnc_state_t  : debouncer FSM states
//   - BTN_* indices : bit positions of the three buttons in the top's vectors
//   - period_for()  : step period in clk cycles for a given speed index
// -----------------------------------------------------------------------------
package shift_ctrl_pkg;

  typedef logic [1:0] speed_t;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    CHK_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    CHK_RELEASE = 2'd3
  } dbnc_state_t;

  // Button ordering inside the top-level vectors.
  localparam int NUM_BTN   = 3;
  localparam int BTN_RUN   = 0;
  localparam int BTN_SPEED = 1;
  localparam int BTN_DIR   = 2;

  // Halving the base period for each speed step: 1, 1/2, 1/4, 1/8 of base.
  function automatic int period_for(input int base, input speed_t s);
    return base >> s;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   One raw push-button: 2-FF synchroniser, polarity normalisation and a
//   four-state debounce FSM. A change of level is accepted only after the new
//   level has been seen for DEBOUNCE_CYCLES further consecutive samples.
//   Ports:
//     clk          system clock
//     rst          asynchronous reset, active low
//     raw          raw asynchronous button level
//     pressed      debounced level (1 = pressed)
//     press_pulse  one-cycle pulse when a press is accepted (none on release)
// -----------------------------------------------------------------------------
module btn_debounce
  import shift_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pressed,
  output logic press_pulse
);

  // The counter only needs to reach DEBOUNCE_CYCLES-1; completion is detected
  // on that value so the accepting edge is the DEBOUNCE_CYCLES-th check edge.
  localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Synchroniser resets to the electrical "not pressed" level so no phantom
  // press appears when reset is released.
  localparam logic            IDLE_LVL = BTN_ACTIVE_LOW;

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level;

  dbnc_state_t      state_reg;
  dbnc_state_t      state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             pulse_reg;
  logic             pulse_next;

  // Synchroniser.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= IDLE_LVL;
      sync2_reg <= IDLE_LVL;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Normalised level: 1 means the button is held down.
  assign level = sync2_reg ^ BTN_ACTIVE_LOW;

  // FSM state register (with its counter and registered pulse).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= RELEASED;
      cnt_reg   <= '0;
      pulse_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pulse_reg <= pulse_next;
    end
  end

  // Next-state logic. Any sample that disagrees with the level being checked
  // abandons the check and returns to the stable state it came from.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pulse_next = 1'b0;
    case (state_reg)
      RELEASED: begin
        cnt_next = '0;
        if (level) begin
          state_next = CHK_PRESS;
        end
      end
      CHK_PRESS: begin
        if (!level) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      PRESSED: begin
        cnt_next = '0;
        if (!level) begin
          state_next = CHK_RELEASE;
        end
      end
      CHK_RELEASE: begin
        if (level) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = RELEASED;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs: the debounced level stays "pressed" while a release is still
  // being confirmed.
  always_comb begin
    pressed     = (state_reg == PRESSED) || (state_reg == CHK_RELEASE);
    press_pulse = pulse_reg;
  end

endmodule

// File: rtl/shift_step_ctrl.sv
// -----------------------------------------------------------------------------
// shift_step_ctrl
//   Control stage for the 4-LED rotator: turns three raw buttons into a
//   run/pause flag, a 2-bit speed index and a direction bit, and issues a
//   one-cycle step pulse every CLK_HZ >> speed cycles while running.
//   Ports:
//     clk        system clock
//     rst        asynchronous reset, active low
//     btn_run    raw button, each press toggles run/pause
//     btn_speed  raw button, each press advances the speed index (mod 4)
//     btn_dir    raw button, each press toggles direction
//     step       one-cycle shift enable for the rotator
//     dir        0: forward rotation, 1: reverse rotation
//     running    1 while steps are being issued
//     speed      current speed index
// -----------------------------------------------------------------------------
module shift_step_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run,
  input  logic       btn_speed,
  input  logic       btn_dir,
  output logic       step,
  output logic       dir,
  output logic       running,
  output logic [1:0] speed
);

  localparam int CNT_W = $clog2(CLK_HZ);

  logic [NUM_BTN-1:0] raw_vec;
  logic [NUM_BTN-1:0] level_vec;
  logic [NUM_BTN-1:0] pulse_vec;
  logic [NUM_BTN-1:0] act_vec;

  logic             step_reg;
  logic             step_next;
  logic             dir_reg;
  logic             dir_next;
  logic             running_reg;
  logic             running_next;
  speed_t           speed_reg;
  speed_t           speed_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] term_cnt;
  logic             at_term;

  assign raw_vec = {btn_dir, btn_speed, btn_run};

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
      ) u_dbnc (
        .clk         (clk),
        .rst         (rst),
        .raw         (raw_vec[gi]),
        .pressed     (level_vec[gi]),
        .press_pulse (pulse_vec[gi])
      );
    end
  endgenerate

  // A press pulse always coincides with the debounced level being "pressed";
  // qualifying with it keeps any glitch on the pulse path from acting alone.
  assign act_vec = pulse_vec & level_vec;

  // Terminal count for the speed currently in force. A speed change takes
  // effect on the period that starts after it, never on the current compare.
  assign term_cnt = CNT_W'(period_for(CLK_HZ, speed_reg) - 1);
  assign at_term  = (cnt_reg == term_cnt);

  always_comb begin
    // The step is decided from the state before this cycle's presses, so a
    // pause or speed press landing on the terminal count still issues it.
    step_next    = running_reg && at_term;
    running_next = running_reg ^ act_vec[BTN_RUN];
    dir_next     = dir_reg ^ act_vec[BTN_DIR];
    speed_next   = speed_reg + speed_t'(act_vec[BTN_SPEED]);

    // Speed change restarts a full period; pausing freezes the count.
    if (act_vec[BTN_SPEED]) begin
      cnt_next = '0;
    end else if (running_reg) begin
      cnt_next = at_term ? '0 : cnt_reg + 1'b1;
    end else begin
      cnt_next = cnt_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_reg    <= 1'b0;
      dir_reg     <= 1'b0;
      running_reg <= 1'b1;
      speed_reg   <= '0;
      cnt_reg     <= '0;
    end else begin
      step_reg    <= step_next;
      dir_reg     <= dir_next;
      running_reg <= running_next;
      speed_reg   <= speed_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign step    = step_reg;
  assign dir     = dir_reg;
  assign running = running_reg;
  assign speed   = speed_reg;

endmodule

// File: tb/tb_shift_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_step_ctrl
//   Bench for shift_step_ctrl with CLK_HZ=16, DEBOUNCE_CYCLES=4, active-low
//   buttons. A behavioural model (run-length debounce, period arithmetic) is
//   compared with the DUT every cycle; a vector table and hand-written
//   sequences check fixed expectations.
// -----------------------------------------------------------------------------
module tb_shift_step_ctrl;

  localparam int CLK_HZ = 16;
  localparam int DEB    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_run = 1'b1;
  logic       btn_speed = 1'b1;
  logic       btn_dir = 1'b1;
  logic       step;
  logic       dir;
  logic       running;
  logic [1:0] speed;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  shift_step_ctrl #(
    .CLK_HZ          (CLK_HZ),
    .DEBOUNCE_CYCLES (DEB),
    .BTN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_run   (btn_run),
    .btn_speed (btn_speed),
    .btn_dir   (btn_dir),
    .step      (step),
    .dir       (dir),
    .running   (running),
    .speed     (speed)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  // Button acceptance: a level differing from the accepted one must be seen on
  // DEB+1 consecutive synchronised samples. Samples lag the pins by two edges;
  // a press is acted on one edge after it is accepted.
  bit [2:0] m_h1, m_h2, m_deb, m_pulse, m_lvl, m_newp;
  int       m_run [3];
  bit       m_running, m_dir, m_step;
  bit [1:0] m_speed;
  int       m_cnt, m_p;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_h1 = '0; m_h2 = '0; m_deb = '0; m_pulse = '0;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
      m_running = 1'b1; m_dir = 1'b0; m_step = 1'b0; m_speed = 2'd0; m_cnt = 0;
    end else begin
      m_p    = CLK_HZ >> m_speed;
      m_step = m_running && (m_cnt + 1 == m_p);
      if (m_pulse[1])     m_cnt = 0;
      else if (m_running) m_cnt = m_step ? 0 : m_cnt + 1;
      if (m_pulse[0]) m_running = !m_running;
      if (m_pulse[1]) m_speed = m_speed + 2'd1;
      if (m_pulse[2]) m_dir = !m_dir;
      m_lvl = m_h2;
      m_h2  = m_h1;
      m_h1  = ~{btn_dir, btn_speed, btn_run};
      m_newp = '0;
      for (int i = 0; i < 3; i++) begin
        if (m_lvl[i] != m_deb[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB + 1) begin
            m_deb[i]  = m_lvl[i];
            m_run[i]  = 0;
            m_newp[i] = m_lvl[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_pulse = m_newp;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    chk("model_step", 32'(step), 32'(m_step));
    chk("model_running", 32'(running), 32'(m_running));
    chk("model_speed", 32'(speed), 32'(m_speed));
    chk("model_dir", 32'(dir), 32'(m_dir));
  endtask

  // mask bit0=run, bit1=speed, bit2=dir; 1 = pressed (pin driven low)
  task automatic set_btns(input logic [2:0] mask);
    btn_run   = ~mask[0];
    btn_speed = ~mask[1];
    btn_dir   = ~mask[2];
  endtask

  task automatic press(input logic [2:0] mask);
    set_btns(mask);
    repeat (8) tick();
    set_btns(3'b000);
    repeat (10) tick();
  endtask

  task automatic do_reset();
    set_btns(3'b000);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    cyc = 0;
  endtask

  typedef struct {
    logic [2:0] btns;
    logic       exp_running;
    logic [1:0] exp_speed;
    logic       exp_dir;
  } vec_t;

  vec_t vecs [8];
  int   n;
  int   hold [3];
  logic [2:0] rmask;
  int   exp_spd [4];
  int   exp_per [4];
  bit   found;

  initial begin
    vecs[0] = '{3'b000, 1'b1, 2'd0, 1'b0};
    vecs[1] = '{3'b010, 1'b1, 2'd1, 1'b0};
    vecs[2] = '{3'b100, 1'b1, 2'd1, 1'b1};
    vecs[3] = '{3'b011, 1'b0, 2'd2, 1'b1};
    vecs[4] = '{3'b010, 1'b0, 2'd3, 1'b1};
    vecs[5] = '{3'b010, 1'b0, 2'd0, 1'b1};
    vecs[6] = '{3'b101, 1'b1, 2'd0, 1'b0};
    vecs[7] = '{3'b111, 1'b0, 2'd1, 1'b1};
    exp_spd = '{1, 2, 3, 0};
    exp_per = '{8, 4, 2, 16};

    #3;
    do_reset();

    // Reset values, then step cadence from reset release.
    chk("reset_step", 32'(step), 0);
    chk("reset_running", 32'(running), 1);
    chk("reset_speed", 32'(speed), 0);
    chk("reset_dir", 32'(dir), 0);
    for (int k = 1; k <= 50; k++) begin
      tick();
      chk("t1_step", 32'(step), 32'((cyc % 16) == 0));
    end
    $display("seq reset_cadence done, cyc=%0d", cyc);

    // Table of button presses with cumulative expected state.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      press(vecs[i].btns);
      chk("vec_running", 32'(running), 32'(vecs[i].exp_running));
      chk("vec_speed", 32'(speed), 32'(vecs[i].exp_speed));
      chk("vec_dir", 32'(dir), 32'(vecs[i].exp_dir));
      $display("vec %0d btns=%b running=%0d speed=%0d dir=%0d", i, vecs[i].btns, running, speed, dir);
    end

    // Bouncing run button, then one clean hold: exactly one toggle.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      btn_run = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      tick();
    end
    btn_run = 1'b0;
    repeat (10) tick();
    btn_run = 1'b1;
    repeat (10) tick();
    chk("t2_paused", 32'(running), 0);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (step) n++;
    end
    chk("t2_no_steps", 32'(n), 0);
    press(3'b001);
    chk("t2_resumed", 32'(running), 1);
    repeat (20) tick();
    $display("seq bounce_run done, running=%0d", running);

    // Four speed presses: each restarts a full period at the new rate.
    do_reset();
    for (int s = 0; s < 4; s++) begin
      btn_speed = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
        tick();
        if (speed == 2'(exp_spd[s])) found = 1'b1;
      end
      chk("t3_speed", 32'(speed), 32'(exp_spd[s]));
      n = 0;
      for (int k = 0; k < 40; k++) begin
        tick();
        n++;
        if (step) break;
      end
      chk("t3_first_gap", 32'(n), 32'(exp_per[s]));
      n = 0;
      for (int k = 0; k < 40; k++) begin
        tick();
        n++;
        if (step) break;
      end
      chk("t3_spacing", 32'(n), 32'(exp_per[s]));
      btn_speed = 1'b1;
      repeat (10) tick();
      $display("seq speed %0d period=%0d", speed, exp_per[s]);
    end

    // Speed pulse on the terminal-count cycle at speed 0.
    do_reset();
    repeat (8) tick();
    btn_speed = 1'b0;
    while (cyc < 15) tick();
    chk("t4_pre_step", 32'(step), 0);
    chk("t4_pre_speed", 32'(speed), 0);
    tick();
    chk("t4_step16", 32'(step), 1);
    chk("t4_speed16", 32'(speed), 1);
    while (cyc < 24) begin
      tick();
      chk("t4_step", 32'(step), 32'(cyc == 24));
    end
    btn_speed = 1'b1;
    repeat (10) tick();
    $display("seq speed_on_terminal done");

    // Direction press latency.
    do_reset();
    repeat (2) tick();
    btn_dir = 1'b0;
    while (cyc < 9) tick();
    chk("t5_dir_before", 32'(dir), 0);
    tick();
    chk("t5_dir_after", 32'(dir), 1);
    while (cyc < 16) begin
      tick();
      chk("t5_step", 32'(step), 32'(cyc == 16));
    end
    btn_dir = 1'b1;
    repeat (10) tick();
    $display("seq dir_latency done");

    // Async reset mid-cycle with a press being debounced.
    do_reset();
    press(3'b001);
    press(3'b100);
    btn_speed = 1'b0;
    repeat (4) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_step", 32'(step), 0);
    chk("t6_async_running", 32'(running), 1);
    chk("t6_async_speed", 32'(speed), 0);
    chk("t6_async_dir", 32'(dir), 0);
    btn_speed = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk("t6_step", 32'(step), 32'((cyc % 16) == 0));
    end
    chk("t6_speed_discarded", 32'(speed), 0);
    $display("seq async_reset done");

    // Random button activity against the model.
    do_reset();
    rmask = 3'b000;
    for (int i = 0; i < 3; i++) hold[i] = $urandom_range(1, 12);
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 3; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          rmask[i] = ~rmask[i];
          hold[i]  = $urandom_range(1, 12);
        end
      end
      set_btns(rmask);
      tick();
    end
    $display("seq random done, running=%0d speed=%0d dir=%0d", running, speed, dir);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
